// File: rtl/tmc4671_spi_master.sv
// SPI mode-3 datagram master for TMC4671-class controllers: one request port, one-hot active-low
// selects, read-data capture, programmable read pause after the address phase and CS guard time.
module tmc4671_spi_master #(
  parameter int CLOCK_FREQ_HZ   = 50_000_000,
  parameter int SPI_FREQ_HZ     = 12_500_000,
  parameter int NUM_SLAVES      = 4,
  parameter int ADDR_WIDTH      = 7,
  parameter int DATA_WIDTH      = 32,
  parameter int READ_DELAY_NS   = 500,
  parameter int CS_GUARD_CYCLES = 2
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  req_valid,
  output logic                                                  req_ready,
  input  logic [((NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1)-1:0] req_slave,
  input  logic                                                  req_write,
  input  logic [ADDR_WIDTH-1:0]                                 req_addr,
  input  logic [DATA_WIDTH-1:0]                                 req_wdata,
  output logic                                                  rsp_valid,
  output logic                                                  rsp_error,
  output logic [DATA_WIDTH-1:0]                                 rsp_rdata,
  output logic                                                  busy,
  output logic                                                  SCK,
  output logic                                                  MOSI,
  input  logic                                                  MISO,
  output logic [NUM_SLAVES-1:0]                                 nSCS
);

  localparam int     H    = CLOCK_FREQ_HZ / (2 * SPI_FREQ_HZ);
  localparam int     N    = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam longint D_L  = (longint'(READ_DELAY_NS) * longint'(CLOCK_FREQ_HZ) + 64'sd999_999_999)
                            / 64'sd1_000_000_000;
  localparam int     D    = int'(D_L);
  localparam int     CM1  = (H > D) ? H : D;
  localparam int     CMAX = (CM1 > CS_GUARD_CYCLES) ? CM1 : CS_GUARD_CYCLES;
  localparam int     CW   = $clog2(CMAX + 1);
  localparam int     IW   = $clog2(N);

  if (H < 1) begin : g_bad_sck_freq
    $error("SPI_FREQ_HZ must not exceed CLOCK_FREQ_HZ/2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_RDELAY, S_HOLD, S_RESP, S_GUARD
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    write_q;
  logic [N-2:0]            sh_q;
  logic [DATA_WIDTH-1:0]   rd_sh_q;
  logic                    req_ready_q, busy_q, rsp_valid_q, rsp_error_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    sck_q, mosi_q;
  logic [NUM_SLAVES-1:0]   nscs_q;
  logic [N-1:0]            frame_d;
  logic [NUM_SLAVES-1:0]   sel_d;
  logic                    slave_ok_d;

  // Request decode: frame image, one-hot select and range check of the slave index.
  always_comb begin
    frame_d    = {req_write, req_addr, req_wdata};
    slave_ok_d = (int'(req_slave) < NUM_SLAVES);
    sel_d      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_d[i] = (int'(req_slave) == i);
    end
  end

  // Frame sequencer; every pin and handshake output is a register written on state transitions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      sh_q        <= '0;
      rd_sh_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      sck_q       <= 1'b1;
      mosi_q      <= 1'b0;
      nscs_q      <= '1;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            write_q     <= req_write;
            if (slave_ok_d) begin
              state_q <= S_SETUP;
              cnt_q   <= CW'(H - 1);
              idx_q   <= IW'(N - 1);
              sh_q    <= frame_d[N-2:0];
              mosi_q  <= frame_d[N-1];
              nscs_q  <= ~sel_d;
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // First falling edge: bit N-1 is already on MOSI, so it is not advanced here.
            state_q <= S_SHIFT;
            sck_q   <= 1'b0;
            cnt_q   <= CW'(H - 1);
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (!sck_q) begin
            sck_q   <= 1'b1;
            rd_sh_q <= {rd_sh_q[DATA_WIDTH-2:0], MISO};
            cnt_q   <= CW'(H - 1);
          end else if (idx_q == '0) begin
            state_q <= S_HOLD;
            cnt_q   <= CW'(H - 1);
          end else if ((D > 0) && !write_q && (idx_q == IW'(DATA_WIDTH))) begin
            state_q <= S_RDELAY;
            cnt_q   <= CW'(D - 1);
          end else begin
            sck_q  <= 1'b0;
            cnt_q  <= CW'(H - 1);
            idx_q  <= idx_q - IW'(1);
            mosi_q <= sh_q[N-2];
            sh_q   <= {sh_q[N-3:0], 1'b0};
          end
        end
        S_RDELAY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q <= S_SHIFT;
            sck_q   <= 1'b0;
            cnt_q   <= CW'(H - 1);
            idx_q   <= idx_q - IW'(1);
            mosi_q  <= sh_q[N-2];
            sh_q    <= {sh_q[N-3:0], 1'b0};
          end
        end
        S_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q     <= S_RESP;
            nscs_q      <= '1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= rd_sh_q;
          end
        end
        S_RESP: begin
          if (CS_GUARD_CYCLES > 0) begin
            state_q <= S_GUARD;
            cnt_q   <= CW'(CS_GUARD_CYCLES - 1);
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_GUARD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          sck_q       <= 1'b1;
          nscs_q      <= '1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
  assign SCK       = sck_q;
  assign MOSI      = mosi_q;
  assign nSCS      = nscs_q;

endmodule

// File: tb/tb_tmc4671_spi_master.sv
// Directed bench: default 4-slave master plus a 1-slave, H=1, 32-bit-frame variant on the same clock.
module tb_tmc4671_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  // Default instance
  logic        m_req_valid = 1'b0, m_req_ready, m_req_write = 1'b0;
  logic [1:0]  m_req_slave = 2'd0;
  logic [6:0]  m_req_addr = 7'd0;
  logic [31:0] m_req_wdata = 32'd0, m_rsp_rdata;
  logic        m_rsp_valid, m_rsp_error, m_busy, m_sck, m_mosi;
  logic        m_miso = 1'b0;
  logic [3:0]  m_nscs;

  // Small instance
  logic        s_req_valid = 1'b0, s_req_ready, s_req_write = 1'b0;
  logic [0:0]  s_req_slave = 1'b0;
  logic [14:0] s_req_addr = 15'd0;
  logic [15:0] s_req_wdata = 16'd0, s_rsp_rdata;
  logic        s_rsp_valid, s_rsp_error, s_busy, s_sck, s_mosi;
  logic        s_miso = 1'b1;
  logic [0:0]  s_nscs;

  tmc4671_spi_master u_dut (
    .clk(clk), .reset(reset), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_slave(m_req_slave), .req_write(m_req_write), .req_addr(m_req_addr),
    .req_wdata(m_req_wdata), .rsp_valid(m_rsp_valid), .rsp_error(m_rsp_error),
    .rsp_rdata(m_rsp_rdata), .busy(m_busy), .SCK(m_sck), .MOSI(m_mosi),
    .MISO(m_miso), .nSCS(m_nscs)
  );

  tmc4671_spi_master #(
    .CLOCK_FREQ_HZ(50_000_000), .SPI_FREQ_HZ(25_000_000), .NUM_SLAVES(1),
    .ADDR_WIDTH(15), .DATA_WIDTH(16), .READ_DELAY_NS(500), .CS_GUARD_CYCLES(2)
  ) u_small (
    .clk(clk), .reset(reset), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_slave(s_req_slave), .req_write(s_req_write), .req_addr(s_req_addr),
    .req_wdata(s_req_wdata), .rsp_valid(s_rsp_valid), .rsp_error(s_rsp_error),
    .rsp_rdata(s_rsp_rdata), .busy(s_busy), .SCK(s_sck), .MOSI(s_mosi),
    .MISO(s_miso), .nSCS(s_nscs)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Pin monitors, sampled on the falling clock edge; cleared by mon_clr.
  logic        mon_clr = 1'b1;
  logic [39:0] miso_word = 40'd0;
  logic [39:0] miso_sh = 40'd0;
  int          m_low [4];
  int          m_rises, m_rsp_cnt, m_nrdy, m_hi_run, m_max_hi, m_gap_run, m_min_gap;
  bit          m_seen_low;
  logic [63:0] m_mosi_sh;
  logic        m_sck_prev = 1'b1;
  logic [3:0]  m_nscs_prev = 4'hF;
  int          s_low, s_rises, s_rsp_cnt, s_nrdy;
  logic [63:0] s_mosi_sh;
  logic        s_sck_prev = 1'b1;

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int k = 0; k < 4; k++) m_low[k] = 0;
      m_rises = 0; m_rsp_cnt = 0; m_nrdy = 0; m_hi_run = 0; m_max_hi = 0;
      m_gap_run = 0; m_min_gap = 1000; m_seen_low = 1'b0; m_mosi_sh = 64'd0;
      s_low = 0; s_rises = 0; s_rsp_cnt = 0; s_nrdy = 0; s_mosi_sh = 64'd0;
    end else begin
      for (int k = 0; k < 4; k++) if (!m_nscs[k]) m_low[k]++;
      if (m_sck && !m_sck_prev) begin
        m_rises++;
        m_mosi_sh = {m_mosi_sh[62:0], m_mosi};
      end
      if (m_nscs != 4'hF && m_sck) m_hi_run++;
      else m_hi_run = 0;
      if (m_hi_run > m_max_hi) m_max_hi = m_hi_run;
      if (m_rsp_valid) m_rsp_cnt++;
      if (!m_req_ready) m_nrdy++;
      if (m_nscs == 4'hF) m_gap_run++;
      else begin
        if (m_seen_low && m_gap_run > 0 && m_gap_run < m_min_gap) m_min_gap = m_gap_run;
        m_gap_run = 0;
        m_seen_low = 1'b1;
      end
      if (!s_nscs[0]) s_low++;
      if (s_sck && !s_sck_prev) begin
        s_rises++;
        s_mosi_sh = {s_mosi_sh[62:0], s_mosi};
      end
      if (s_rsp_valid) s_rsp_cnt++;
      if (!s_req_ready) s_nrdy++;
    end
    // Mode-3 slave model: each SCK fall presents the next bit of miso_word, MSB first.
    if (m_nscs_prev == 4'hF && m_nscs != 4'hF) miso_sh = miso_word;
    if (!m_sck && m_sck_prev && m_nscs != 4'hF) begin
      m_miso  = miso_sh[39];
      miso_sh = {miso_sh[38:0], 1'b0};
    end
    m_sck_prev  = m_sck;
    m_nscs_prev = m_nscs;
    s_sck_prev  = s_sck;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic start_main(input logic [1:0] sl, input logic wr, input logic [6:0] ad,
                            input logic [31:0] wd);
    m_req_slave = sl; m_req_write = wr; m_req_addr = ad; m_req_wdata = wd;
    m_req_valid = 1'b1;
    step();
    m_req_valid = 1'b0;
  endtask

  task automatic wait_main_rsp(input string tag);
    int n;
    n = 0;
    while (m_rsp_valid !== 1'b1 && n < 1000) begin step(); n++; end
    check({tag, "_rsp_seen"}, m_rsp_valid, 1'b1);
  endtask

  task automatic wait_main_ready(input string tag);
    int n;
    n = 0;
    while (m_req_ready !== 1'b1 && n < 1000) begin step(); n++; end
    check({tag, "_ready_back"}, m_req_ready, 1'b1);
  endtask

  task automatic wait_small_ready(input string tag);
    int n;
    n = 0;
    while (s_req_ready !== 1'b1 && n < 1000) begin step(); n++; end
    check({tag, "_ready_back"}, s_req_ready, 1'b1);
  endtask

  initial begin
    int acc, overlap, n;

    // Reset state
    repeat (3) step();
    check("rst_nscs", m_nscs, 4'hF);
    check("rst_sck", m_sck, 1'b1);
    check("rst_mosi", m_mosi, 1'b0);
    check("rst_ready", m_req_ready, 1'b1);
    check("rst_busy", m_busy, 1'b0);
    check("rst_rsp_valid", m_rsp_valid, 1'b0);
    check("rst_rsp_error", m_rsp_error, 1'b0);
    check("rst_rdata", m_rsp_rdata, 32'd0);
    check("rst_s_nscs", s_nscs, 1'b1);
    check("rst_s_ready", s_req_ready, 1'b1);
    reset = 1'b0;
    step();

    // Write slave 0, addr 0x01, data 0xDEADBEEF
    clear_mon();
    start_main(2'd0, 1'b1, 7'h01, 32'hDEADBEEF);
    check("wr_busy", m_busy, 1'b1);
    wait_main_rsp("wr");
    check("wr_rsp_error", m_rsp_error, 1'b0);
    check("wr_nscs_at_rsp", m_nscs, 4'hF);
    wait_main_ready("wr");
    check("wr_nscs0_low", m_low[0], 164);
    check("wr_sck_rises", m_rises, 40);
    check("wr_mosi", m_mosi_sh[39:0], 40'h81DEADBEEF);
    check("wr_rsp_cnt", m_rsp_cnt, 1);
    check("wr_accept_to_ready", m_nrdy, 167);

    // Read slave 2, addr 0x7F, slave returns 0x12345678 in the data phase
    miso_word = {8'h5A, 32'h12345678};
    clear_mon();
    start_main(2'd2, 1'b0, 7'h7F, 32'h00000000);
    wait_main_rsp("rd");
    check("rd_rdata", m_rsp_rdata, 32'h12345678);
    check("rd_rsp_error", m_rsp_error, 1'b0);
    wait_main_ready("rd");
    check("rd_nscs2_low", m_low[2], 189);
    check("rd_other_cs", m_low[0] + m_low[1] + m_low[3], 0);
    check("rd_sck_rises", m_rises, 40);
    check("rd_mosi", m_mosi_sh[39:0], 40'h7F00000000);
    // longest SCK-high run: last address bit's high half (2) plus the 25-cycle pause
    check("rd_pause_len", m_max_hi, 27);
    check("rd_rdata_held", m_rsp_rdata, 32'h12345678);

    // req_valid held high across three requests
    clear_mon();
    m_req_slave = 2'd1; m_req_write = 1'b1; m_req_addr = 7'h10; m_req_wdata = 32'h000000FF;
    m_req_valid = 1'b1;
    acc = 0; overlap = 0; n = 0;
    while (acc < 3 && n < 2000) begin
      if (m_req_ready && m_busy) overlap++;
      if (m_req_ready) acc++;
      step();
      n++;
    end
    m_req_valid = 1'b0;
    wait_main_rsp("b2b");
    wait_main_ready("b2b");
    check("b2b_accepts", acc, 3);
    check("b2b_ready_busy_overlap", overlap, 0);
    check("b2b_rsp_cnt", m_rsp_cnt, 3);
    check("b2b_nscs1_low", m_low[1], 3 * 164);
    check("b2b_guard_ok", (m_min_gap >= 2 && m_min_gap < 1000), 1'b1);

    // Invalid slave index on the one-slave variant
    clear_mon();
    s_req_slave = 1'b1; s_req_write = 1'b1; s_req_addr = 15'h0001; s_req_wdata = 16'h1111;
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    check("inv_rsp_valid", s_rsp_valid, 1'b1);
    check("inv_rsp_error", s_rsp_error, 1'b1);
    check("inv_rdata_kept", s_rsp_rdata, 16'h0000);
    check("inv_nscs", s_nscs, 1'b1);
    step();
    check("inv_rsp_pulse_end", s_rsp_valid, 1'b0);
    wait_small_ready("inv");
    check("inv_sck_rises", s_rises, 0);
    check("inv_nscs_low", s_low, 0);
    check("inv_rsp_cnt", s_rsp_cnt, 1);

    // Write on the one-slave, H=1, 32-bit-frame variant (MISO tied high)
    clear_mon();
    s_req_slave = 1'b0; s_req_write = 1'b1; s_req_addr = 15'h1234; s_req_wdata = 16'hBEEF;
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    n = 0;
    while (s_rsp_valid !== 1'b1 && n < 500) begin step(); n++; end
    check("sm_rsp_seen", s_rsp_valid, 1'b1);
    check("sm_rsp_error", s_rsp_error, 1'b0);
    check("sm_rdata", s_rsp_rdata, 16'hFFFF);
    wait_small_ready("sm");
    check("sm_nscs_low", s_low, 66);
    check("sm_sck_rises", s_rises, 32);
    check("sm_mosi", s_mosi_sh[31:0], 32'h9234BEEF);
    check("sm_accept_to_ready", s_nrdy, 69);

    // Reset at bit 20 of a read, then a normal write
    miso_word = {8'h00, 32'hCAFEF00D};
    clear_mon();
    start_main(2'd3, 1'b0, 7'h22, 32'h00000000);
    n = 0;
    while (m_rises < 20 && n < 500) begin step(); n++; end
    check("mid_reached_bit20", m_rises >= 20, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_nscs", m_nscs, 4'hF);
    check("mid_rst_sck", m_sck, 1'b1);
    check("mid_rst_rsp_valid", m_rsp_valid, 1'b0);
    check("mid_rst_busy", m_busy, 1'b0);
    check("mid_rst_rdata", m_rsp_rdata, 32'd0);
    repeat (3) step();
    reset = 1'b0;
    step();
    check("mid_no_rsp", m_rsp_cnt, 0);
    clear_mon();
    start_main(2'd3, 1'b1, 7'h05, 32'h0BADF00D);
    wait_main_rsp("post");
    check("post_rsp_error", m_rsp_error, 1'b0);
    wait_main_ready("post");
    check("post_nscs3_low", m_low[3], 164);
    check("post_sck_rises", m_rises, 40);
    check("post_mosi", m_mosi_sh[39:0], 40'h850BADF00D);
    check("post_rsp_cnt", m_rsp_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
